dual_bank_window_buffer: RTL and testbench
==========================================

// Module: dual_bank_window_buffer
// PURPOSE
//  Double-banked successor of the single-chain window buffer: two MAX_ROW x MAX_COL shift-register
//  banks that ping-pong, so one window fills from the pixel stream while the other drains as
//  NUM_OUTPUTS parallel lanes. Adds valid/ready handshakes on both sides, backpressure, frame-end
//  marking and a synchronous flush. Sits between the pixel source and the parallel window processors.
// PARAMETERS
//  BITWIDTH     8   pixel width in bits
//  MAX_ROW      35  window rows; must be divisible by NUM_OUTPUTS
//  MAX_COL      20  window columns
//  NUM_OUTPUTS  7   parallel output lanes
//  (derived) L = MAX_ROW*MAX_COL pixels per window; BLOCK_LEN = (MAX_ROW/NUM_OUTPUTS)*MAX_COL drain beats
// PORTS
//  clock     in   1                    single clock; all state updates on the rising edge
//  reset     in   1                    asynchronous, active-high
//  flush     in   1                    sync clear of control state (flags, selects, counters)
//  in_valid  in   1                    in_data is valid
//  in_ready  out  1                    buffer accepts in_data this cycle
//  in_data   in   BITWIDTH             pixel, raster order
//  out_valid out  1                    out_data holds a valid beat
//  out_ready in   1                    consumer accepts the beat
//  out_data  out  NUM_OUTPUTS*BITWIDTH lane k in bits [k*BITWIDTH +: BITWIDTH]
//  out_last  out  1                    final beat of the current window
// BEHAVIOUR
//  - Reset: all bank registers 0, wr_sel=0, rd_sel=0, full[1:0]=0, wr_cnt=0, rd_cnt=0.
//    Outputs: in_ready=1, out_valid=0, out_last=0, out_data=0.
//  - Each bank is a chain of L registers. Position 1 holds the newest pixel; position L holds the oldest.
//  - Write: in_ready = !full[wr_sel]. When in_valid&&in_ready, bank[wr_sel] shifts in in_data
//    and wr_cnt increments. When the beat at wr_cnt==L-1 is accepted: full[wr_sel]<=1,
//    wr_sel toggles, wr_cnt<=0. The write bank never shifts at any other time.
//  - Read: out_valid = full[rd_sel]. Lane k taps bank[rd_sel] position BLOCK_LEN*(NUM_OUTPUTS-k).
//    For window pixels p0..p(L-1), beat j (j = 0..BLOCK_LEN-1) shows lane k = p(k*BLOCK_LEN+j).
//  - Drain: when out_valid&&out_ready, bank[rd_sel] shifts by one (zero fed in) and rd_cnt increments.
//    out_last = out_valid && rd_cnt==BLOCK_LEN-1. When the last beat is accepted: full[rd_sel]<=0,
//    rd_sel toggles, rd_cnt<=0.
//  - Stall: while out_valid && !out_ready, out_data and out_last stay stable. in_data is ignored when !in_ready.
//  - out_data is driven from the read-bank taps even when out_valid=0. Consumers must qualify with out_valid.
//  - Latency: after the last write beat is accepted at edge t, out_valid=1 in the cycle following t
//    if that bank is rd_sel. Otherwise it follows the drain of the other bank.
//    in_ready recovers the cycle after a drain completes.
//  - Simultaneous completion: a fill completion and a drain completion in the same cycle always
//    target different banks. Both take effect, so the filling bank becomes full and the drained bank becomes free.
//  - Both full: in_ready=0 until the read bank's last beat is accepted.
//  - Both empty: wr_sel==rd_sel, out_valid=0.
//  - flush: highest priority. full<=0, wr_sel<=0, rd_sel<=0, wr_cnt<=0, rd_cnt<=0. Handshakes in
//    that cycle are discarded and bank data is not cleared. out_valid=0 and in_ready=1 from the next cycle.
//  - Reset mid-window: immediate return to reset state, and the partial window is lost.
//  - Counter widths: wr_cnt is clog2(L) bits and rd_cnt is clog2(BLOCK_LEN) bits, with minimum 1 bit each.
//    No wrap beyond terminal counts.
// TESTING (bench params BITWIDTH=8, MAX_ROW=4, MAX_COL=3, NUM_OUTPUTS=2 -> L=12, BLOCK_LEN=6)
//  1. Reset, then stream 0..11 with out_ready=1 -> out_valid=1 the cycle after pixel 11.
//     Beat j out_data lanes are {j, 6+j}. out_last is asserted on beat 5 only. Then out_valid=0.
//  2. Write 0..11 and 12..23 with out_ready=0 -> in_ready=0 after pixel 23 is accepted.
//     Raise out_ready: window 1 drains {j,6+j}, in_ready=1 the cycle after its last beat, then window 2 drains {12+j,18+j}.
//  3. Toggle out_ready randomly during a drain -> out_data is held while stalled and exactly 6 beats are accepted,
//     in order, with no duplicates.
//  4. Write the last pixel of window B in the same cycle the last beat of window A is accepted ->
//     next cycle full flags show B full and A empty, out_valid=1, in_ready=1, and B beat 0 = {B0,B6}.
//  5. Assert flush after 5 pixels, then stream 100..111 -> the first window out is {100+j,106+j}.
//     No pixels from before the flush appear.
//  6. Assert reset asynchronously mid-drain (between edges) -> out_valid, out_last and out_data go to 0
//     and in_ready goes to 1 immediately. A subsequent clean window behaves as in test 1.

Source files
------------

// File: rtl/dual_bank_window_buffer.sv
// dual_bank_window_buffer
//   Two ping-pong shift-register banks of MAX_ROW*MAX_COL pixels. One bank
//   fills from a raster pixel stream while the other drains as NUM_OUTPUTS
//   parallel lanes, with valid/ready handshakes on both sides.
//
// Ports
//   clock     : single clock, rising edge
//   reset     : asynchronous, active-high
//   flush     : synchronous clear of control state (bank data kept)
//   in_valid  : in_data is valid
//   in_ready  : write bank can accept a pixel this cycle
//   in_data   : pixel, raster order
//   out_valid : out_data holds a valid beat
//   out_ready : consumer accepts the beat
//   out_data  : lane k in bits [k*BITWIDTH +: BITWIDTH]
//   out_last  : final beat of the current window
module dual_bank_window_buffer #(
  parameter int BITWIDTH    = 8,
  parameter int MAX_ROW     = 35,
  parameter int MAX_COL     = 20,
  parameter int NUM_OUTPUTS = 7
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [BITWIDTH-1:0]             in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_OUTPUTS*BITWIDTH-1:0] out_data,
  output logic                            out_last
);

  localparam int L         = MAX_ROW * MAX_COL;
  localparam int BLOCK_LEN = (MAX_ROW / NUM_OUTPUTS) * MAX_COL;
  localparam int WR_W      = (L > 1) ? $clog2(L) : 1;
  localparam int RD_W      = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

  // bank[b][0] is position 1 (newest pixel), bank[b][L-1] is position L (oldest).
  logic [BITWIDTH-1:0] bank [2][L];

  logic [1:0]      full;
  logic            wr_sel;
  logic            rd_sel;
  logic [WR_W-1:0] wr_cnt;
  logic [RD_W-1:0] rd_cnt;

  logic                wr_fire;
  logic                rd_fire;
  logic                wr_last;
  logic                rd_last;
  logic [1:0]          shift_en;
  logic [BITWIDTH-1:0] shift_in [2];

  assign in_ready  = !full[wr_sel];
  assign out_valid = full[rd_sel];
  assign wr_last   = (wr_cnt == WR_W'(L - 1));
  assign rd_last   = (rd_cnt == RD_W'(BLOCK_LEN - 1));
  assign out_last  = out_valid && rd_last;

  // Handshakes coinciding with flush are discarded.
  assign wr_fire = in_valid && in_ready && !flush;
  assign rd_fire = out_valid && out_ready && !flush;

  // A bank is either filling or draining, never both: writes need it empty,
  // reads need it full. Draining feeds zeros into position 1.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    shift_en    = '0;
    shift_in[0] = '0;
    shift_in[1] = '0;
    if (wr_fire) begin
      shift_en[wr_sel] = 1'b1;
      shift_in[wr_sel] = in_data;
    end
    if (rd_fire) begin
      shift_en[rd_sel] = 1'b1;
    end
  end

  // NOTE: the bank storage is reset too, so out_data (read straight from the taps) is 0 after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < L; i++)
          bank[b][i] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (shift_en[b]) begin
          bank[b][0] <= shift_in[b];
          for (int i = 1; i < L; i++)
            bank[b][i] <= bank[b][i-1];
        end
      end
    end
  end

  // Fill and drain completions in one cycle always hit different banks,
  // so both full-flag updates can take effect together.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      full   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else if (flush) begin
      full   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_last) begin
          full[wr_sel] <= 1'b1;
          wr_sel       <= !wr_sel;
          wr_cnt       <= '0;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      if (rd_fire) begin
        if (rd_last) begin
          full[rd_sel] <= 1'b0;
          rd_sel       <= !rd_sel;
          rd_cnt       <= '0;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

  // Lane k taps position BLOCK_LEN*(NUM_OUTPUTS-k) of the read bank.
  for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_lane
    assign out_data[k*BITWIDTH +: BITWIDTH] = bank[rd_sel][BLOCK_LEN*(NUM_OUTPUTS-k)-1];
  end

endmodule

// File: tb/tb_dual_bank_window_buffer.sv
// tb_dual_bank_window_buffer
//   Directed bench for dual_bank_window_buffer with a 4x3 window and two
//   lanes (L=12, BLOCK_LEN=6). Inputs change and outputs are sampled on the
//   falling edge; the design updates on the rising edge.
module tb_dual_bank_window_buffer;

  localparam int BW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*BW-1:0] out_data;
  logic          out_last;

  int n_checks = 0;
  int n_fails  = 0;

  dual_bank_window_buffer #(
    .BITWIDTH(BW), .MAX_ROW(4), .MAX_COL(3), .NUM_OUTPUTS(2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered and left just after a falling edge.
  task automatic write_px(input logic [BW-1:0] v);
    in_valid = 1'b1;
    in_data  = v;
    for (int i = 0; i < 100 && !in_ready; i++) @(negedge clock);
    check("wr_ready", 32'(in_ready), 1);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic write_window(input int base);
    for (int i = 0; i < 12; i++) write_px(BW'(base + i));
  endtask

  task automatic read_beat(input int lane0, input int lane1, input bit last);
    out_ready = 1'b1;
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clock);
    check("rd_valid", 32'(out_valid), 1);
    check("rd_data", 32'(out_data), 32'({BW'(lane1), BW'(lane0)}));
    check("rd_last", 32'(out_last), 32'(last));
    @(negedge clock);
  endtask

  task automatic read_window(input int base);
    for (int j = 0; j < 6; j++) read_beat(base + j, base + 6 + j, j == 5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;

    // ---- 1: reset state, single window streamed with out_ready high
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_out_data", 32'(out_data), 0);
    out_ready = 1'b1;
    write_window(0);
    check("t1_valid_after_fill", 32'(out_valid), 1);
    read_window(0);
    check("t1_valid_after_drain", 32'(out_valid), 0);
    check("t1_ready_after_drain", 32'(in_ready), 1);

    // ---- 2: both banks fill under backpressure
    out_ready = 1'b0;
    write_window(0);
    write_window(12);
    check("t2_both_full_ready", 32'(in_ready), 0);
    check("t2_both_full_valid", 32'(out_valid), 1);
    read_window(0);
    check("t2_ready_recovers", 32'(in_ready), 1);
    read_window(12);
    check("t2_empty_valid", 32'(out_valid), 0);

    // ---- 3: random stalls during a drain
    out_ready = 1'b0;
    write_window(50);
    acc = 0;
    for (int c = 0; c < 200 && acc < 6; c++) begin
      out_ready = (c > 60) ? 1'b1 : 1'($urandom_range(0, 1));
      check("t3_valid", 32'(out_valid), 1);
      check("t3_data", 32'(out_data), 32'({BW'(56 + acc), BW'(50 + acc)}));
      check("t3_last", 32'(out_last), 32'(acc == 5));
      @(posedge clock);
      if (out_ready) acc++;
      @(negedge clock);
    end
    out_ready = 1'b0;
    check("t3_beats", 32'(acc), 6);
    check("t3_no_extra", 32'(out_valid), 0);

    // ---- 4: fill of B completes on the same edge as the drain of A
    write_window(0);
    for (int i = 0; i < 11; i++) write_px(BW'(20 + i));
    for (int j = 0; j < 5; j++) read_beat(j, 6 + j, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'd31;
    out_ready = 1'b1;
    check("t4_pre_last", 32'(out_last), 1);
    check("t4_pre_ready", 32'(in_ready), 1);
    @(negedge clock);
    in_valid = 1'b0;
    // A sits in bank 0, B in bank 1 at this point of the sequence.
    check("t4_full_flags", 32'(dut.full), 32'(2'b10));
    check("t4_valid", 32'(out_valid), 1);
    check("t4_ready", 32'(in_ready), 1);
    check("t4_b_beat0", 32'(out_data), 32'({8'd26, 8'd20}));
    read_window(20);
    check("t4_empty", 32'(out_valid), 0);

    // ---- 5: flush drops a partial window
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) write_px(BW'(200 + i));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd99;
    @(negedge clock);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("t5_flush_valid", 32'(out_valid), 0);
    check("t5_flush_ready", 32'(in_ready), 1);
    write_window(100);
    read_window(100);
    check("t5_empty", 32'(out_valid), 0);

    // ---- 6: asynchronous reset in the middle of a drain
    write_window(0);
    read_beat(0, 6, 1'b0);
    read_beat(1, 7, 1'b0);
    check("t6_pre_data", 32'(out_data), 32'({8'd8, 8'd2}));
    #2 reset = 1'b1;
    #1;
    check("t6_rst_valid", 32'(out_valid), 0);
    check("t6_rst_last", 32'(out_last), 0);
    check("t6_rst_data", 32'(out_data), 0);
    check("t6_rst_ready", 32'(in_ready), 1);
    @(negedge clock);
    reset = 1'b0;
    out_ready = 1'b1;
    write_window(0);
    check("t6_clean_valid", 32'(out_valid), 1);
    read_window(0);
    check("t6_clean_empty", 32'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
